// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: access-size codes and FSM states shared by the data-memory responder.
package dm_responder_pkg;
  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/dm_lane.sv
// dm_lane: load lane extraction/extension, store byte-enable merge and misalign detect.
module dm_lane
  import dm_responder_pkg::*;
(
  input  logic [31:0] w,
  input  logic [31:0] din,
  input  logic [1:0]  off,
  input  logic [2:0]  ctrl,
  output logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        mis
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        is_w, is_h, is_b;
  logic [31:0] rep;
  always_comb begin
    b     = w[{off, 3'b000} +: 8];
    h     = off[1] ? w[31:16] : w[15:0];
    is_w  = ctrl == dm_word;
    is_h  = ctrl == dm_halfword || ctrl == dm_halfword_unsigned;
    is_b  = ctrl == dm_byte || ctrl == dm_byte_unsigned;
    mis   = (is_w && off != 2'b00) || (is_h && off[0]);
    rdata = mis ? '0 : is_w ? w :
            is_h ? {{16{h[15] && ctrl == dm_halfword}}, h} :
            is_b ? {{24{b[7] && ctrl == dm_byte}}, b} : '0;
    be    = mis ? 4'h0 : is_w ? 4'hF : is_h ? (off[1] ? 4'hC : 4'h3) :
            is_b ? 4'b0001 << off : 4'h0;
    // store data is right-aligned; replicate so every candidate lane sees it
    rep   = is_w ? din : is_h ? {2{din[15:0]}} : {4{din[7:0]}};
    wdata = w;
    for (int i = 0; i < 4; i++) wdata[8*i +: 8] = be[i] ? rep[8*i +: 8] : w[8*i +: 8];
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: data memory with zero-init sweep, sized loads/stores and misalign counting.
// Optional DM_MMIO_EN maps an io_out register at MMIO_ADDR.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 8
`ifdef DM_MMIO_EN
  ,
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF_0000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_in,
  input  logic [2:0]        dm_ctrl,
  output logic [31:0]       Data_out,
  output logic              init_done,
  output logic              misalign_err,
  output logic [ERR_W-1:0]  err_count
`ifdef DM_MMIO_EN
  ,
  output logic [31:0]       io_out
`endif
);
  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] idx, widx;
  logic [31:0]       w, rdata, wdata;
  logic [3:0]        be;
  logic              mis, mmio, run, st, unused_addr;
  assign widx        = Addr_in[ADDR_W+1:2];
  assign unused_addr = ^Addr_in[31:ADDR_W+2];
  assign w           = mem[widx];
  assign run         = state == ST_RUN;
  assign st          = run && mem_w && !mmio;
  dm_lane u_lane (
    .w(w), .din(Data_in), .off(Addr_in[1:0]), .ctrl(dm_ctrl),
    .rdata(rdata), .wdata(wdata), .be(be), .mis(mis)
  );
`ifdef DM_MMIO_EN
  assign mmio     = Addr_in == MMIO_ADDR;
  assign Data_out = !run ? '0 : mmio ? (dm_ctrl == dm_word ? io_out : '0) : rdata;
  always_ff @(posedge clk) begin
    if (reset) io_out <= '0;
    else if (run && mem_w && mmio && dm_ctrl == dm_word) io_out <= Data_in;
  end
`else
  assign mmio     = 1'b0;
  assign Data_out = run ? rdata : '0;
`endif
  // single write port: sweep address during INIT, core address in RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) mem[idx] <= '0;
      else if (st && be != 4'h0) mem[widx] <= wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      idx          <= '0;
      init_done    <= 1'b0;
      misalign_err <= 1'b0;
      err_count    <= '0;
    end else if (!run) begin
      idx <= idx + 1'b1;
      if (idx == ADDR_W'(DEPTH - 1)) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end else if (st && mis) begin
      misalign_err <= 1'b1;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end
endmodule
